sram_master: RTL and testbench

- Processor-side initiator for the external asynchronous SRAM bus; the SRAM is the responder.
- Takes single-beat read/write requests on a valid/ready interface.
- Generates ce/oe/we strobes, address and a tri-stated data bus with programmable setup, pulse and hold timing.
- Returns read data or write completion on a one-cycle response pulse. Replaces the board-level glue that derives ce/oe/we from MemWrite.

---
 rtl/sram_master.sv | 146 ++++++++++++++
 tb/tb_sram_master.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_master.sv
// sram_master: single-beat read/write initiator for an external asynchronous SRAM.
// Latency: rsp_valid pulses SETUP_CYCLES + PULSE_CYCLES + HOLD_CYCLES + 1 cycles after acceptance.
// Backpressure: req_ready is high only in IDLE; one transaction in flight and the response cannot stall.
//
// Ports:
//   clk, reset                    rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake; req_write/req_adr/req_wdata captured on accept
//   rsp_valid/rsp_rdata           one-cycle completion pulse; rsp_rdata holds the last read value
//   ce, oe, we                    active-low SRAM strobes (registered)
//   adr                           SRAM address (registered, stable while ce is low)
//   data                          bidirectional SRAM data, driven only during writes
module sram_master #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_adr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ce,
  output logic                  oe,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] adr,
  inout  wire  [DATA_WIDTH-1:0] data
);

  localparam int MAX_SP = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int MAX_T  = (MAX_SP > HOLD_CYCLES) ? MAX_SP : HOLD_CYCLES;
  localparam int CNT_W  = $clog2(MAX_T) + 1;

  // Counter is loaded with (cycles - 1) and the phase ends when it reaches zero.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_PULSE = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_write;
  logic                  r_drive;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic                  r_ce;
  logic                  r_oe;
  logic                  r_we;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  logic                  w_cnt_done;

  assign w_cnt_done = (r_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_drive     <= 1'b0;
      r_wdata     <= '0;
      r_adr       <= '0;
      r_ce        <= 1'b1;
      r_oe        <= 1'b1;
      r_we        <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      // Completion is a single-cycle pulse; only the HOLD exit raises it.
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_state <= S_SETUP;
            r_cnt   <= SETUP_LD;
            r_write <= req_write;
            r_adr   <= req_adr;
            r_wdata <= req_wdata;
            r_ce    <= 1'b0;
            // Write data goes on the bus from the first SETUP cycle.
            r_drive <= req_write;
          end
        end
        S_SETUP: begin
          if (w_cnt_done) begin
            r_state <= S_PULSE;
            r_cnt   <= PULSE_LD;
            r_oe    <= r_write;
            r_we    <= ~r_write;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_PULSE: begin
          if (w_cnt_done) begin
            r_state <= S_HOLD;
            r_cnt   <= HOLD_LD;
            r_oe    <= 1'b1;
            r_we    <= 1'b1;
            // Sample on the edge that ends the strobe, while oe is still low.
            if (!r_write) begin
              r_rsp_rdata <= data;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (w_cnt_done) begin
            r_state     <= S_IDLE;
            r_ce        <= 1'b1;
            r_drive     <= 1'b0;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign ce        = r_ce;
  assign oe        = r_oe;
  assign we        = r_we;
  assign adr       = r_adr;
  assign data      = r_drive ? r_wdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_master.sv
module tb_sram_master;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   viol1    = 0;
  int   viol2    = 0;

  // Default-timing instance
  logic          rv1, wr1, rdy1, rspv1, ce1, oe1, we1;
  logic [AW-1:0] ad1, adr1;
  logic [DW-1:0] wd1, rsd1;
  wire  [DW-1:0] data1;

  // SETUP=2, PULSE=1, HOLD=3 instance
  logic          rv2, wr2, rdy2, rspv2, ce2, oe2, we2;
  logic [AW-1:0] ad2, adr2;
  logic [DW-1:0] wd2, rsd2;
  wire  [DW-1:0] data2;

  sram_master u_dut1 (
    .clk(clk), .reset(rst_n), .req_valid(rv1), .req_ready(rdy1), .req_write(wr1),
    .req_adr(ad1), .req_wdata(wd1), .rsp_valid(rspv1), .rsp_rdata(rsd1),
    .ce(ce1), .oe(oe1), .we(we1), .adr(adr1), .data(data1)
  );

  sram_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SETUP_CYCLES(2), .PULSE_CYCLES(1), .HOLD_CYCLES(3)) u_dut2 (
    .clk(clk), .reset(rst_n), .req_valid(rv2), .req_ready(rdy2), .req_write(wr2),
    .req_adr(ad2), .req_wdata(wd2), .rsp_valid(rspv2), .rsp_rdata(rsd2),
    .ce(ce2), .oe(oe2), .we(we2), .adr(adr2), .data(data2)
  );

  // Asynchronous SRAM devices: drive on ce&oe low, store on the rising edge of we.
  logic [DW-1:0] sram1 [256];
  logic [DW-1:0] sram2 [256];
  assign data1 = (!ce1 && !oe1) ? sram1[adr1] : {DW{1'bz}};
  assign data2 = (!ce2 && !oe2) ? sram2[adr2] : {DW{1'bz}};
  always @(posedge we1) if (!ce1) sram1[adr1] = data1;
  always @(posedge we2) if (!ce2) sram2[adr2] = data2;

  // Reference contents as the requester sees them
  logic [DW-1:0] ref1 [256];
  logic [DW-1:0] ref2 [256];
  logic [DW-1:0] exp_last1;
  logic [DW-1:0] exp_last2;

  // Released bus has no bit at 1 (reads as z, or 0 in a two-state simulator).
  function automatic bit released(input logic [DW-1:0] v);
    return ($countones(v) == 0);
  endfunction

  // Bus invariants on both instances
  logic [AW-1:0] padr1, padr2;
  logic pce1 = 1'b1;
  logic pce2 = 1'b1;
  always @(negedge clk) begin
    if (rst_n) begin
      if (!oe1 && !we1) viol1++;
      if ((!oe1 || !we1) && ce1) viol1++;
      if (!ce1 && !pce1 && adr1 != padr1) viol1++;
      if (!oe1 && $isunknown(data1)) viol1++;
      if (!oe2 && !we2) viol2++;
      if ((!oe2 || !we2) && ce2) viol2++;
      if (!ce2 && !pce2 && adr2 != padr2) viol2++;
      if (!oe2 && $isunknown(data2)) viol2++;
    end
    pce1 = ce1; padr1 = adr1;
    pce2 = ce2; padr2 = adr2;
  end

  // One transaction; histories are indexed by cycles after acceptance (bit 1 = first SETUP cycle).
  task automatic txn(input bit sel, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     output logic [DW-1:0] rd, output int lat,
                     output logic [31:0] ce_h, output logic [31:0] oe_h, output logic [31:0] we_h,
                     output logic [31:0] drv_h, output logic [31:0] rel_h);
    int guard;
    ce_h = '0; oe_h = '0; we_h = '0; drv_h = '0; rel_h = '0;
    @(negedge clk);
    if (sel) begin rv2 = 1'b1; wr2 = w; ad2 = a; wd2 = d; end
    else     begin rv1 = 1'b1; wr1 = w; ad1 = a; wd1 = d; end
    guard = 0;
    while (!(sel ? rdy2 : rdy1) && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    if (sel) rv2 = 1'b0; else rv1 = 1'b0;
    lat = 1;
    while (lat < 31) begin
      ce_h[lat]  = sel ? !ce2 : !ce1;
      oe_h[lat]  = sel ? !oe2 : !oe1;
      we_h[lat]  = sel ? !we2 : !we1;
      drv_h[lat] = sel ? (data2 === d) : (data1 === d);
      rel_h[lat] = sel ? released(data2) : released(data1);
      if (sel ? rspv2 : rspv1) break;
      @(negedge clk);
      lat++;
    end
    rd = sel ? rsd2 : rsd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if ({ce1, oe1, we1} !== 3'b111) begin failures++; $display("FAIL rst_strobes got=%b exp=111", {ce1, oe1, we1}); end
    checks++; if (adr1 !== 8'h00) begin failures++; $display("FAIL rst_adr got=%h exp=00", adr1); end
    checks++; if (rspv1 !== 1'b0 || rsd1 !== 16'h0000) begin failures++; $display("FAIL rst_rsp got=%b/%h exp=0/0000", rspv1, rsd1); end
    checks++; if (!released(data1)) begin failures++; $display("FAIL rst_data got=%h exp=released", data1); end
    checks++; if (rdy1 !== 1'b1 || rdy2 !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b%b exp=11", rdy1, rdy2); end
    rst_n = 1'b1;
    exp_last1 = '0; exp_last2 = '0;
  endtask

  task automatic test_write_read();
    logic [DW-1:0] rd; int lat; logic [31:0] c, o, w, dv, rl;
    txn(0, 1, 8'h20, 16'h002D, rd, lat, c, o, w, dv, rl);
    ref1[8'h20] = 16'h002D;
    checks++; if (lat != 5) begin failures++; $display("FAIL wr_latency got=%0d exp=5", lat); end
    txn(0, 0, 8'h20, 16'h5A5A, rd, lat, c, o, w, dv, rl);
    checks++; if (lat != 5) begin failures++; $display("FAIL rd_latency got=%0d exp=5", lat); end
    checks++; if (rd !== ref1[8'h20]) begin failures++; $display("FAIL rd_data got=%h exp=%h", rd, ref1[8'h20]); end
    exp_last1 = ref1[8'h20];
  endtask

  task automatic test_strobe_timing();
    logic [DW-1:0] rd, d; int lat; logic [31:0] c, o, w, dv, rl;
    d = 16'($urandom) | 16'h0001;
    txn(0, 1, 8'h30, d, rd, lat, c, o, w, dv, rl);
    ref1[8'h30] = d;
    checks++; if (c !== 32'b11110) begin failures++; $display("FAIL st_ce got=%b exp=11110", c[7:0]); end
    checks++; if (w !== 32'b01100) begin failures++; $display("FAIL st_we got=%b exp=01100", w[7:0]); end
    checks++; if (o !== 32'b0) begin failures++; $display("FAIL st_oe got=%b exp=0", o[7:0]); end
    checks++; if (dv !== 32'b11110) begin failures++; $display("FAIL st_drive got=%b exp=11110", dv[7:0]); end
    checks++; if (rd !== exp_last1) begin failures++; $display("FAIL st_rdata_kept got=%h exp=%h", rd, exp_last1); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] rd; int lat; logic [31:0] c, o, w, dv, rl;
    logic [DW-1:0] rsp [2];
    int n_rsp, gap, guard; bit acc2, coinc, seen2low;
    txn(0, 1, 8'h00, 16'h1111, rd, lat, c, o, w, dv, rl); ref1[8'h00] = 16'h1111;
    txn(0, 1, 8'h01, 16'h2222, rd, lat, c, o, w, dv, rl); ref1[8'h01] = 16'h2222;
    @(negedge clk);
    rv1 = 1'b1; wr1 = 1'b0; ad1 = 8'h00; wd1 = 16'hA5A5;
    guard = 0;
    while (!rdy1 && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    ad1 = 8'h01;
    n_rsp = 0; gap = 0; acc2 = 0; coinc = 0; seen2low = 0;
    for (int i = 0; i < 30 && n_rsp < 2; i++) begin
      if (rspv1) begin rsp[n_rsp] = rsd1; n_rsp++; end
      if (!acc2 && rdy1) begin acc2 = 1; coinc = rspv1; end
      if (acc2 && !ce1) seen2low = 1;
      if (ce1 && !seen2low) gap++;
      @(negedge clk);
      if (acc2) rv1 = 1'b0;
    end
    rv1 = 1'b0;
    checks++; if (coinc !== 1'b1) begin failures++; $display("FAIL b2b_accept_with_rsp got=%b exp=1", coinc); end
    checks++; if (n_rsp != 2) begin failures++; $display("FAIL b2b_rsp_count got=%0d exp=2", n_rsp); end
    else begin
      checks++; if (rsp[0] !== 16'h1111) begin failures++; $display("FAIL b2b_rsp0 got=%h exp=1111", rsp[0]); end
      checks++; if (rsp[1] !== 16'h2222) begin failures++; $display("FAIL b2b_rsp1 got=%h exp=2222", rsp[1]); end
    end
    checks++; if (gap != 1) begin failures++; $display("FAIL b2b_ce_gap got=%0d exp=1", gap); end
    exp_last1 = 16'h2222;
  endtask

  task automatic test_busy_ignore();
    logic [DW-1:0] rd; int lat, guard, bad_rdy, bad_adr, bad_we, bad_drv, toggled; bit got;
    @(negedge clk);
    rv1 = 1'b1; wr1 = 1'b0; ad1 = 8'h20; wd1 = 16'hBEEF;
    guard = 0;
    while (!rdy1 && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    bad_rdy = 0; bad_adr = 0; bad_we = 0; bad_drv = 0; toggled = 0; got = 0; rd = '0;
    for (lat = 1; lat < 30; lat++) begin
      if (rspv1) begin got = 1; rd = rsd1; rv1 = 1'b0; break; end
      if (rdy1) bad_rdy++;
      if (adr1 !== 8'h20) bad_adr++;
      if (!we1) bad_we++;
      if (oe1 && !released(data1)) bad_drv++;
      if (!oe1) begin ad1 = 8'hFF; wr1 = ~wr1; toggled++; end
      @(negedge clk);
    end
    rv1 = 1'b0; wr1 = 1'b0;
    checks++; if (!got || lat != 5) begin failures++; $display("FAIL busy_latency got=%0d exp=5", lat); end
    checks++; if (rd !== 16'h002D) begin failures++; $display("FAIL busy_rdata got=%h exp=002D", rd); end
    checks++; if (bad_rdy != 0) begin failures++; $display("FAIL busy_ready got=%0d exp=0", bad_rdy); end
    checks++; if (bad_adr != 0 || bad_we != 0) begin failures++; $display("FAIL busy_captured got=adr%0d/we%0d exp=0/0", bad_adr, bad_we); end
    checks++; if (bad_drv != 0) begin failures++; $display("FAIL busy_read_drive got=%0d exp=0", bad_drv); end
    checks++; if (toggled != 2) begin failures++; $display("FAIL busy_oe_cycles got=%0d exp=2", toggled); end
    @(negedge clk);
    checks++; if (rdy1 !== 1'b1 || ce1 !== 1'b1) begin failures++; $display("FAIL busy_idle got=%b%b exp=11", rdy1, ce1); end
    exp_last1 = 16'h002D;
  endtask

  task automatic test_random();
    logic [DW-1:0] rd, d; logic [AW-1:0] a; int lat; bit w; logic [31:0] c, o, wh, dv, rl;
    for (int i = 0; i < 8; i++) begin
      d = 16'($urandom);
      txn(0, 1, AW'(8'h40 + i), d, rd, lat, c, o, wh, dv, rl);
      ref1[8'h40 + i] = d;
    end
    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom_range(0, 1));
      a = AW'(8'h40 + $urandom_range(0, 7));
      d = 16'($urandom);
      txn(0, w, a, d, rd, lat, c, o, wh, dv, rl);
      checks++; if (lat != 5) begin failures++; $display("FAIL rnd_latency[%0d] got=%0d exp=5", i, lat); end
      if (w) begin
        ref1[a] = d;
        checks++; if (rd !== exp_last1) begin failures++; $display("FAIL rnd_wr_rdata_kept[%0d] got=%h exp=%h", i, rd, exp_last1); end
      end else begin
        checks++; if (rd !== ref1[a]) begin failures++; $display("FAIL rnd_rd[%0d] adr=%h got=%h exp=%h", i, a, rd, ref1[a]); end
        exp_last1 = ref1[a];
      end
    end
  endtask

  task automatic test_param_sweep();
    logic [DW-1:0] rd, d; int lat; logic [31:0] c, o, w, dv, rl;
    d = 16'($urandom) | 16'h0001;
    txn(1, 1, 8'h33, d, rd, lat, c, o, w, dv, rl);
    ref2[8'h33] = d;
    checks++; if (lat != 7) begin failures++; $display("FAIL sw_wr_latency got=%0d exp=7", lat); end
    checks++; if (c !== 32'b1111110 || w !== 32'b0001000) begin failures++; $display("FAIL sw_wr_strobes got=ce%b/we%b exp=1111110/0001000", c[7:0], w[7:0]); end
    txn(1, 0, 8'h33, 16'hFFFF, rd, lat, c, o, w, dv, rl);
    checks++; if (lat != 7) begin failures++; $display("FAIL sw_rd_latency got=%0d exp=7", lat); end
    checks++; if (o !== 32'b0001000) begin failures++; $display("FAIL sw_oe got=%b exp=0001000", o[7:0]); end
    checks++; if (rd !== ref2[8'h33]) begin failures++; $display("FAIL sw_rdata got=%h exp=%h", rd, ref2[8'h33]); end
    checks++; if ((rl & 32'b1110110) !== 32'b1110110) begin failures++; $display("FAIL sw_read_drive got=%b exp=1110110", rl[7:0]); end
    exp_last2 = ref2[8'h33];
  endtask

  task automatic test_reset_mid_write();
    int guard, saw_rsp, nrdy;
    @(negedge clk);
    rv1 = 1'b1; wr1 = 1'b1; ad1 = 8'h10; wd1 = 16'hA5A5;
    guard = 0;
    while (!rdy1 && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    rv1 = 1'b0;
    guard = 0;
    while (we1 && guard < 10) begin @(negedge clk); guard++; end
    checks++; if (we1 !== 1'b0 || data1 !== 16'hA5A5) begin failures++; $display("FAIL rmw_pulse got=we%b/%h exp=0/A5A5", we1, data1); end
    rst_n = 1'b0;
    #1;
    checks++; if ({ce1, oe1, we1} !== 3'b111) begin failures++; $display("FAIL rmw_strobes got=%b exp=111", {ce1, oe1, we1}); end
    checks++; if (!released(data1)) begin failures++; $display("FAIL rmw_data got=%h exp=released", data1); end
    checks++; if (rsd1 !== 16'h0000) begin failures++; $display("FAIL rmw_rdata got=%h exp=0000", rsd1); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    saw_rsp = 0; nrdy = 0;
    repeat (10) begin
      @(negedge clk);
      if (rspv1) saw_rsp++;
      if (!rdy1) nrdy++;
    end
    checks++; if (saw_rsp != 0) begin failures++; $display("FAIL rmw_no_rsp got=%0d exp=0", saw_rsp); end
    checks++; if (nrdy != 0 || ce1 !== 1'b1) begin failures++; $display("FAIL rmw_ready got=%0d/ce%b exp=0/1", nrdy, ce1); end
    exp_last1 = '0;
  endtask

  task automatic test_invariants();
    checks++; if (viol1 != 0) begin failures++; $display("FAIL inv_default got=%0d exp=0", viol1); end
    checks++; if (viol2 != 0) begin failures++; $display("FAIL inv_sweep got=%0d exp=0", viol2); end
  endtask

  initial begin
    rst_n = 1'b1;
    rv1 = 1'b0; wr1 = 1'b0; ad1 = '0; wd1 = '0;
    rv2 = 1'b0; wr2 = 1'b0; ad2 = '0; wd2 = '0;
    test_reset();
    test_write_read();
    test_strobe_timing();
    test_back_to_back();
    test_busy_ignore();
    test_random();
    test_param_sweep();
    test_reset_mid_write();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
